// File: rtl/ble_cfg_pkg.sv
// ble_cfg_pkg: shared types and constants for the BLE configuration loader.
//   cfg_state_t  - loader FSM states (IDLE / SHIFT / COMMIT)
//   LUT_BITS_DEF - default truth-table width (16)
//   PARITY_BITS  - 1 when BLE_CFG_PARITY_EN is defined, else 0
//   FRAME_LEN    - serial frame length: LUT bits + mode bit (+ parity bit)
//   CNT_W        - width of the frame bit counter
// Optional feature macro: BLE_CFG_PARITY_EN (adds an even-parity bit to each frame).
package ble_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } cfg_state_t;

  localparam int LUT_BITS_DEF = 16;

`ifdef BLE_CFG_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  localparam int FRAME_LEN = LUT_BITS_DEF + 1 + PARITY_BITS;
  localparam int CNT_W     = 5;

endpackage

// File: rtl/ble_cfg_shift.sv
// ble_cfg_shift: shadow register, bit counter and parity accumulator for one
// configuration frame.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - clear counter, shadow and parity (new frame / restart)
//   en         - accept din as frame bit number cnt
//   din        - serial frame bit
//   shadow     - assembled LUT bits [SH_W-2:0] and mode bit [SH_W-1]
//   last       - the counter points at the final frame bit (N-1)
//   par        - XOR of every bit accepted since the last clear
// Parameters: SH_W (shadow width), N (frame length in bits).
// The parity bit (when present) is folded into par only; it has no shadow slot.
module ble_cfg_shift
  import ble_cfg_pkg::*;
#(
  parameter int SH_W = LUT_BITS_DEF + 1,
  parameter int N    = FRAME_LEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  input  logic            din,
  output logic [SH_W-1:0] shadow,
  output logic            last,
  output logic            par
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      shadow <= '0;
      par    <= 1'b0;
    end else if (clr) begin
      cnt    <= '0;
      shadow <= '0;
      par    <= 1'b0;
    end else if (en) begin
      // Bits at indices >= SH_W (the parity bit) only feed the accumulator.
      for (int i = 0; i < SH_W; i++) begin
        if (cnt == CNT_W'(i)) shadow[i] <= din;
      end
      // The loader stops enabling after bit N-1, so cnt never passes N.
      cnt <= cnt + 1'b1;
      par <= par ^ din;
    end
  end

  assign last = (cnt == CNT_W'(N - 1));

endmodule

// File: rtl/ble_cfg_loader.sv
// ble_cfg_loader: serial configuration loader for one BLE. A bit-serial
// frame is assembled in a shadow register and committed atomically to the
// LUT truth table (lut_s) and the registered-output mode bit (ff_en), so the
// downstream LUT mux never sees a partially written table.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   cfg_start  - begin (or restart) a frame
//   cfg_valid  - cfg_din holds a frame bit
//   cfg_din    - serial frame bit; bit k of the frame is lut_s[k] for
//                k < LUT_BITS, then ff_en, then the optional parity bit
//   cfg_ready  - loader accepts a bit this cycle
//   lut_s      - committed truth table
//   ff_en      - committed mode bit (1 = registered LUT output)
//   cfg_done   - one-cycle pulse in the first cycle new lut_s/ff_en are visible
//   cfg_err    - sticky parity error, cleared by cfg_start (constant 0 unless
//                BLE_CFG_PARITY_EN is defined)
//   busy       - frame in progress (SHIFT or COMMIT)
// Handshake: a bit transfers on a rising edge where cfg_valid && cfg_ready;
// cfg_valid may drop for any number of cycles between bits, and cfg_ready is
// a registered function of the FSM state only.
// Optional feature macro: BLE_CFG_PARITY_EN (even parity over the whole frame).
module ble_cfg_loader
  import ble_cfg_pkg::*;
#(
  parameter int LUT_BITS = LUT_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  input  logic                cfg_din,
  output logic                cfg_ready,
  output logic [LUT_BITS-1:0] lut_s,
  output logic                ff_en,
  output logic                cfg_done,
  output logic                cfg_err,
  output logic                busy
);

  localparam int N = LUT_BITS + 1 + PARITY_BITS;

  cfg_state_t      state;
  logic            sh_clr;
  logic            sh_en;
  logic            sh_last;
  logic            sh_par;
  logic            frame_ok;
  logic [LUT_BITS:0] shadow;

  // A start in IDLE opens a frame; a start in SHIFT restarts it and the
  // bit presented in that same cycle is dropped.
  assign sh_clr = cfg_start && (state == ST_IDLE || state == ST_SHIFT);
  assign sh_en  = (state == ST_SHIFT) && cfg_valid && !cfg_start;

  ble_cfg_shift #(
    .SH_W (LUT_BITS + 1),
    .N    (N)
  ) u_shift (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (sh_clr),
    .en     (sh_en),
    .din    (cfg_din),
    .shadow (shadow),
    .last   (sh_last),
    .par    (sh_par)
  );

`ifdef BLE_CFG_PARITY_EN
  // Even parity: the XOR over all frame bits, parity bit included, is 0.
  assign frame_ok = ~sh_par;
`else
  logic unused_par;
  assign unused_par = sh_par;
  assign frame_ok   = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cfg_ready <= 1'b0;
      busy      <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      lut_s     <= '0;
      ff_en     <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_start) begin
            state     <= ST_SHIFT;
            cfg_ready <= 1'b1;
            busy      <= 1'b1;
            cfg_err   <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (sh_en && sh_last) begin
            state     <= ST_COMMIT;
            cfg_ready <= 1'b0;
          end
        end
        ST_COMMIT: begin
          // The shadow and parity already include the final bit here.
          state <= ST_IDLE;
          busy  <= 1'b0;
          if (frame_ok) begin
            lut_s    <= shadow[LUT_BITS-1:0];
            ff_en    <= shadow[LUT_BITS];
            cfg_done <= 1'b1;
          end else begin
            cfg_err <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cfg_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ble_cfg_loader.sv
// tb_ble_cfg_loader: self-checking bench for ble_cfg_loader. A frame-level
// reference model (queue of accepted bits) predicts every output each cycle;
// directed frames pin known truth tables and latencies, then randomized
// frames with gaps, restarts and ignored starts run against the model.
// Honours BLE_CFG_PARITY_EN the same way as the design.
module tb_ble_cfg_loader;

  localparam int LB = 16;
`ifdef BLE_CFG_PARITY_EN
  localparam int NB = LB + 2;
`else
  localparam int NB = LB + 1;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_start = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_din = 1'b0;
  logic          cfg_ready;
  logic [LB-1:0] lut_s;
  logic          ff_en;
  logic          cfg_done;
  logic          cfg_err;
  logic          busy;

  always #5 clk = ~clk;

  ble_cfg_loader #(.LUT_BITS(LB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_din   (cfg_din),
    .cfg_ready (cfg_ready),
    .lut_s     (lut_s),
    .ff_en     (ff_en),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .busy      (busy)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_seen = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // m_open: a frame is collecting bits; m_commit: a full frame waits one
  // cycle before its result becomes visible.
  bit            m_open;
  bit            m_commit;
  bit            m_q[$];
  logic [LB-1:0] m_lut;
  bit            m_ff;
  bit            m_done;
  bit            m_err;

  function automatic bit frame_good();
    bit x = 1'b0;
    foreach (m_q[i]) x ^= m_q[i];
    return (NB == LB + 1) || (x == 1'b0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_open = 0; m_commit = 0; m_q.delete();
      m_lut = '0; m_ff = 0; m_done = 0; m_err = 0;
    end else begin
      cyc++;
      m_done = 0;
      if (m_commit) begin
        m_commit = 0;
        if (frame_good()) begin
          for (int k = 0; k < LB; k++) m_lut[k] = m_q[k];
          m_ff = m_q[LB];
          m_done = 1;
        end else begin
          m_err = 1;
        end
      end else if (cfg_start) begin
        m_open = 1;
        m_q.delete();
        m_err = 0;
      end else if (m_open && cfg_valid) begin
        m_q.push_back(cfg_din);
        if (m_q.size() == NB) begin
          m_open = 0;
          m_commit = 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("cfg_ready", 32'(cfg_ready), 32'(m_open));
      check("busy", 32'(busy), 32'(m_open || m_commit));
      check("lut_s", 32'(lut_s), 32'(m_lut));
      check("ff_en", 32'(ff_en), 32'(m_ff));
      check("cfg_done", 32'(cfg_done), 32'(m_done));
      check("cfg_err", 32'(cfg_err), 32'(m_err));
      if (cfg_done) done_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic send_bit(input bit b, input int maxgap);
    int g;
    g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    repeat (g) begin
      cfg_valid = 1'b0;
      cfg_din = 1'($urandom_range(1, 0));
      tick();
    end
    cfg_valid = 1'b1;
    cfg_din = b;
    tick();
    cfg_valid = 1'b0;
  endtask

  // Sends all frame bits; bad flips the parity bit when one is present.
  task automatic send_bits(input logic [LB-1:0] l, input bit f, input bit bad, input int maxgap);
    bit fb[$];
    for (int k = 0; k < LB; k++) fb.push_back(l[k]);
    fb.push_back(f);
    if (NB > LB + 1) fb.push_back((^{f, l}) ^ bad);
    foreach (fb[i]) send_bit(fb[i], maxgap);
  endtask

  task automatic send_frame(input logic [LB-1:0] l, input bit f, input bit bad, input int maxgap);
    start_frame();
    send_bits(l, f, bad, maxgap);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "timeout");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int d0;
    chk_en = 1'b1;
    #12;
    check("rst_lut", 32'(lut_s), 32'h0);
    check("rst_ff", 32'(ff_en), 32'h0);
    check("rst_ready", 32'(cfg_ready), 32'h0);
    check("rst_done", 32'(cfg_done), 32'h0);
    check("rst_err", 32'(cfg_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // AND4: only k15 and the mode bit set
    start_frame();
    check("and4_ready_after_start", 32'(cfg_ready), 32'h1);
    send_bits(16'h8000, 1'b1, 1'b0, 0);
    check("and4_lut_held", 32'(lut_s), 32'h0);
    check("and4_no_early_done", 32'(cfg_done), 32'h0);
    tick();
    check("and4_lut", 32'(lut_s), 32'h8000);
    check("and4_ff", 32'(ff_en), 32'h1);
    check("and4_done", 32'(cfg_done), 32'h1);
    tick();
    check("and4_done_single", 32'(cfg_done), 32'h0);

    // XOR pattern with valid gaps
    send_frame(16'h6996, 1'b0, 1'b0, 5);
    check("xor_lut_held", 32'(lut_s), 32'h8000);
    tick();
    check("xor_lut", 32'(lut_s), 32'h6996);
    check("xor_done", 32'(cfg_done), 32'h1);
    tick();

    // Restart after 9 bits
    start_frame();
    for (int k = 0; k < 9; k++) send_bit(1'b1, 0);
    d0 = done_seen;
    send_frame(16'h00FF, 1'b0, 1'b0, 2);
    check("restart_no_early_done", 32'(done_seen), 32'(d0));
    tick();
    check("restart_lut", 32'(lut_s), 32'h00FF);
    check("restart_done", 32'(cfg_done), 32'h1);
    tick();

    // Asynchronous reset mid-frame
    send_frame(16'hFFFF, 1'b1, 1'b0, 0);
    tick(); tick();
    check("pre_rst_lut", 32'(lut_s), 32'hFFFF);
    start_frame();
    for (int k = 0; k < 10; k++) send_bit(1'b0, 0);
    rst_n = 1'b0;
    #1;
    check("arst_lut", 32'(lut_s), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_ff", 32'(ff_en), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cfg_valid = 1'b1;
      cfg_din = 1'($urandom_range(1, 0));
      tick();
    end
    cfg_valid = 1'b0;
    check("idle_ignores_ready", 32'(cfg_ready), 32'h0);
    check("idle_ignores_lut", 32'(lut_s), 32'h0);
    check("idle_ignores_busy", 32'(busy), 32'h0);

`ifdef BLE_CFG_PARITY_EN
    send_frame(16'hA5A5, 1'b1, 1'b0, 0);
    tick(); tick();
    send_frame(16'h8000, 1'b0, 1'b1, 0);
    tick();
    check("par_lut_kept", 32'(lut_s), 32'hA5A5);
    check("par_no_done", 32'(cfg_done), 32'h0);
    check("par_err", 32'(cfg_err), 32'h1);
    tick(); tick(); tick();
    check("par_err_sticky", 32'(cfg_err), 32'h1);
    start_frame();
    check("par_err_cleared", 32'(cfg_err), 32'h0);
    send_bits(16'h8000, 1'b0, 1'b0, 0);
    tick();
    check("par_resend_lut", 32'(lut_s), 32'h8000);
    check("par_resend_done", 32'(cfg_done), 32'h1);
    tick();
`endif

    // Back-to-back frames, second start in the done cycle
    d0 = done_seen;
    send_frame(16'hC3C3, 1'b0, 1'b0, 1);
    tick();
    check("b2b_first_done", 32'(cfg_done), 32'h1);
    send_frame(16'h1234, 1'b1, 1'b0, 0);
    tick();
    check("b2b_second_done", 32'(cfg_done), 32'h1);
    check("b2b_lut", 32'(lut_s), 32'h1234);
    tick();
    check("b2b_two_pulses", 32'(done_seen - d0), 32'h2);

    // Randomized frames against the model
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(4, 0) == 0) begin
        start_frame();
        repeat ($urandom_range(NB - 2, 0)) send_bit(1'($urandom_range(1, 0)), 2);
      end
      send_frame(16'($urandom), 1'($urandom_range(1, 0)),
                 ($urandom_range(3, 0) == 0), 3);
      // start during the commit cycle must be ignored
      if ($urandom_range(3, 0) == 0) cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      repeat ($urandom_range(3, 0)) begin
        cfg_valid = 1'($urandom_range(1, 0));
        cfg_din = 1'($urandom_range(1, 0));
        tick();
      end
      cfg_valid = 1'b0;
      if (busy) begin
        // a start landed in COMMIT was dropped; a leftover open frame
        // cannot exist here, but close it cleanly if it did
        repeat (NB) send_bit(1'b0, 0);
        tick();
      end
    end
    tick(); tick();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ble_cfg_loader.md
# ble_cfg_loader

Serial configuration loader for one basic logic element (BLE). It receives a bit-serial frame, assembles it in a shadow register and commits it atomically to the 16-bit LUT truth table. The truth table drives the `s[15:0]` input of the BLE's 16:1 LUT multiplexer, and the loader also supplies the BLE's registered-output mode bit. It sits directly upstream of the LUT mux. Active outputs never change mid-frame, so the mux output cannot glitch during reconfiguration.

## Interface
- `LUT_BITS`, default 16: truth-table width; must equal 2^(LUT select width).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cfg_start` in 1: one-cycle request to begin a new frame.
- `cfg_valid` in 1: `cfg_din` carries a frame bit this cycle.
- `cfg_din` in 1: serial frame bit.
- `cfg_ready` out 1: loader accepts a bit this cycle. A bit transfers when `cfg_valid && cfg_ready`.
- `lut_s` out `LUT_BITS`: committed truth table, feeds LUT mux `s`.
- `ff_en` out 1: committed BLE mode; 1 selects the registered LUT output.
- `cfg_done` out 1: one-cycle pulse, high in the first cycle new `lut_s`/`ff_en` are visible.
- `cfg_err` out 1: sticky parity error (tied 0 without `BLE_CFG_PARITY_EN`).
- `busy` out 1: high in SHIFT and COMMIT.

## Operation
- Frame layout, bit index k counted in acceptance order:
  - k = 0..15 → `lut_s[k]`
  - k = 16 → `ff_en`
  - k = 17 → parity bit, present only with `BLE_CFG_PARITY_EN`.
- Frame length N = 17, or 18 with parity.
- FSM states IDLE, SHIFT, COMMIT.
  - IDLE: `cfg_ready` = 0; `cfg_valid` is ignored. `cfg_start` → SHIFT; bit counter and shadow are cleared; `cfg_err` is cleared.
  - SHIFT: `cfg_ready` = 1. Each transfer writes the shadow bit at counter index, then the counter increments. Gaps, meaning `cfg_valid` low, are allowed indefinitely. Accepting bit N-1 → COMMIT.
  - SHIFT with `cfg_start` high: restart. Counter and shadow are cleared; any bit presented that cycle is discarded; the state stays SHIFT. Active outputs are unchanged.
  - COMMIT: one cycle; `cfg_ready` = 0; `cfg_start` is ignored. At the exit edge, on a good check, shadow → `lut_s`/`ff_en` and `cfg_done` is set. The state returns to IDLE.
- The counter is 5 bits and never wraps. Bits beyond N are impossible because `cfg_ready` drops after bit N-1.
- Reset mid-frame, via async `rst_n` low at any time: FSM → IDLE, counter and shadow → 0, active registers → 0.

## Timing
- Reset values:
  - `lut_s` = 0 (constant-0 LUT)
  - `ff_en` = 0
  - `cfg_ready` = 0
  - `cfg_done` = 0
  - `cfg_err` = 0
  - `busy` = 0
- `cfg_start` sampled at edge E0 → `cfg_ready` is high from the cycle after E0.
- Final bit accepted at edge E → COMMIT during cycle E..E+1. At edge E+1, `lut_s`/`ff_en` update and `cfg_done` goes high for exactly one cycle.
- Commit latency is 2 edges from the final bit. Minimum frame time is N+2 cycles after start.
- `cfg_done` drops at E+2. Back-to-back frames are allowed: `cfg_start` may be asserted in the `cfg_done` cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `BLE_CFG_PARITY_EN` defined:
  - Frame carries an 18th bit. Even parity: the XOR of all 18 bits must be 0.
  - On mismatch in COMMIT: active registers are not updated, `cfg_done` stays 0, and `cfg_err` sets and holds until the next `cfg_start` or reset.
- `BLE_CFG_PARITY_EN` not defined:
  - N = 17, no check, every completed frame commits, `cfg_err` is constant 0.

## Structure
- Package `ble_cfg_pkg` holds:
  - state enum (IDLE/SHIFT/COMMIT)
  - `LUT_BITS_DEF` = 16
  - `FRAME_LEN` (17/18 per macro)
  - `CNT_W` = 5
- One sub-module, `ble_cfg_shift`: shadow register plus bit counter, with clear/enable inputs, a `last` flag and a parity accumulator. The FSM and active registers stay in `ble_cfg_loader`.

## Test plan
- Reset, then an AND4 frame: `cfg_start`, then bits k0..k15 = 0 except k15 = 1, and k16 = 1. Expect:
  - `lut_s` = 16'h8000 and `ff_en` = 1, exactly 2 edges after the last bit
  - a single `cfg_done` pulse
  - `lut_s` held at 0 throughout shifting.
- XOR-pattern frame 16'h6996 with random `cfg_valid` gaps of 0–5 cycles → `lut_s` = 16'h6996, same commit latency from the last accepted bit.
- Restart: `cfg_start` after 9 bits, then a full frame 16'h00FF → `lut_s` = 16'h00FF with no contamination from the partial frame, and no `cfg_done` before completion.
- `rst_n` low for 1 cycle mid-frame (bit 10) after a prior commit of 16'hFFFF → `lut_s` = 0 and `busy` = 0 immediately (asynchronous), and IDLE ignores `cfg_valid`.
- With `BLE_CFG_PARITY_EN`: frame 16'h8000 with `ff_en` = 0 and wrong parity bit 0. Expect:
  - `lut_s` retains its previous value
  - `cfg_done` = 0
  - `cfg_err` = 1 until the next `cfg_start`.
  - Resending with parity bit 1 commits 16'h8000.
- Back-to-back: `cfg_start` in the `cfg_done` cycle, second frame 16'h1234 → two `cfg_done` pulses, and the final `lut_s` = 16'h1234.
